idex_hazard_reg: RTL
====================

Name: idex_hazard_reg

Overview:
- ID/EX pipeline register with integrated load-use hazard detection. Sits between decode and the execute stage.
- Supplies the IDEX rs/rt/opcode and control fields that the EX-stage forwarding unit consumes.
- Inserts a one-cycle bubble on load-use, zeroes its contents on branch flush, and freezes on external stall.
- Drives PCWrite/IFIDWrite back to fetch.

Parameters:
- DATA_W, 32, width of operand, immediate and PC fields
- REG_AW, 5, register-specifier width

Ports:
- Clk  input  1  rising-edge clock
- Rst  input  1  asynchronous active-low reset
- IFIDInstr  input  32  instruction held in IF/ID
- IFIDPCPlus4  input  DATA_W  PC+4 from IF/ID
- RsData  input  DATA_W  register file read port 1
- RtData  input  DATA_W  register file read port 2
- ImmExt  input  DATA_W  sign-extended immediate
- CtrlIn  input  10  decoded control {RegWrite, MemRead, MemWrite, MemToReg, ALUSrc, RegDst, ALUOp[3:0]}
- Flush  input  1  branch/jump resolved taken; kill the ID instruction
- ExtStall  input  1  downstream busy; hold the whole front end
- IDEXOpCode  output  6  latched opcode
- IDEXrs  output  REG_AW  latched rs
- IDEXrt  output  REG_AW  latched rt
- IDEXrd  output  REG_AW  latched rd
- IDEXRsData  output  DATA_W  latched operand
- IDEXRtData  output  DATA_W  latched operand
- IDEXImm  output  DATA_W  latched immediate
- IDEXPCPlus4  output  DATA_W  latched PC+4
- IDEXCtrl  output  10  latched control, same packing as CtrlIn
- PCWrite  output  1  PC update enable (combinational)
- IFIDWrite  output  1  IF/ID update enable (combinational)
- Bubble  output  1  high while IDEX holds an inserted bubble

Behaviour:
- Field extraction from IFIDInstr: opcode [31:26], rs [25:21], rt [20:16], rd [15:11].
- Source use:
  - opcode 000000 uses rs and rt.
  - 101011 (sw), 000100 (beq), 000101 (bne) use rs and rt.
  - 000010 (j) uses neither.
  - All other opcodes use rs only.
- Load-use hazard (combinational): IDEXCtrl.MemRead=1, IDEXrt!=0, and IDEXrt equals a used source of the IF/ID instruction.
- Bubble content: every registered field and IDEXCtrl = 0.
- Two-state FSM, RUN and BUBBLE. Per-edge priority, highest first:
  1. Rst low (async): all registered outputs 0, Bubble=0, state RUN. PCWrite=0 and IFIDWrite=0 while Rst is low.
  2. ExtStall=1: all registers and state hold. PCWrite=0, IFIDWrite=0. Flush and hazard are ignored this cycle.
  3. Flush=1: load bubble, state RUN, Bubble=1. PCWrite=1, IFIDWrite=1; fetch owns redirect and IF/ID clear.
  4. Hazard=1 in RUN: load bubble, state BUBBLE, Bubble=1. PCWrite=0, IFIDWrite=0 during the detecting cycle.
  5. Otherwise: capture ID fields, state RUN, Bubble=0. PCWrite=1, IFIDWrite=1.
- In BUBBLE, IDEXCtrl.MemRead is 0, so the hazard cannot re-fire; the next edge captures the held instruction. Stall length is exactly 1 cycle per load-use.
- Latency: the ID instruction appears on the IDEX outputs 1 cycle after capture.
- rt=0 never triggers a hazard; r0 is a hardwired zero.
- Reset deasserted mid-stall: the FSM restarts in RUN; the pending instruction is re-evaluated from IF/ID.
- Back-to-back loads: each load-use pair stalls independently, one cycle each.

Optional Feature:
- Macro HAZARD_PERF_CNT_EN.
- When defined:
  - Adds output StallCount [15:0].
  - Counts cycles where Hazard or Flush produced a bubble; ExtStall cycles are not counted.
  - Saturates at 16'hFFFF; async-cleared by Rst.
- When undefined: the port and counter are absent and behaviour is otherwise identical.

Test Plan:
- Reset: Rst=0 mid-run → all IDEX outputs 0, Bubble=0, PCWrite=0 immediately; after release, the first edge captures IFIDInstr normally.
- Load-use: IDEX holds lw rt=5; IF/ID add rs=5 → PCWrite=IFIDWrite=0 one cycle, next IDEXCtrl=0 and Bubble=1, following edge IDEXrs=5, Bubble=0.
- No false hazard:
  - lw rt=0 followed by add rs=0 → no stall.
  - lw rt=7 followed by addi rt=7 (rt not used) → no stall.
  - lw rt=7 followed by sw rt=7 → stall.
- Flush over hazard: hazard condition plus Flush=1 → bubble loaded, PCWrite=1, state RUN, no second bubble.
- ExtStall over flush: ExtStall=1 with Flush=1 for 3 cycles → IDEX outputs unchanged, PCWrite=0. Flush then honoured on the first cycle after ExtStall drops.
- With HAZARD_PERF_CNT_EN: 2 load-use stalls plus 1 flush → StallCount=3. Preload 16'hFFFF plus a further stall → stays 16'hFFFF.

Source files
------------

// File: rtl/idex_hazard_reg.sv
// idex_hazard_reg: ID/EX pipeline register with load-use hazard detection.
// Inserts a one-cycle bubble on load-use, zeroes on branch flush, freezes on
// external stall, and drives PCWrite/IFIDWrite back to fetch.
// Optional feature macro: HAZARD_PERF_CNT_EN (adds the StallCount output).
//
// state  | meaning
// RUN    | normal flow; IDEX captures decode each unstalled edge
// BUBBLE | a load-use bubble was just inserted; next edge captures held instr

module idex_hazard_reg #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic [31:0]       IFIDInstr,
  input  logic [DATA_W-1:0] IFIDPCPlus4,
  input  logic [DATA_W-1:0] RsData,
  input  logic [DATA_W-1:0] RtData,
  input  logic [DATA_W-1:0] ImmExt,
  input  logic [9:0]        CtrlIn,
  input  logic              Flush,
  input  logic              ExtStall,
  output logic [5:0]        IDEXOpCode,
  output logic [REG_AW-1:0] IDEXrs,
  output logic [REG_AW-1:0] IDEXrt,
  output logic [REG_AW-1:0] IDEXrd,
  output logic [DATA_W-1:0] IDEXRsData,
  output logic [DATA_W-1:0] IDEXRtData,
  output logic [DATA_W-1:0] IDEXImm,
  output logic [DATA_W-1:0] IDEXPCPlus4,
  output logic [9:0]        IDEXCtrl,
  output logic              PCWrite,
  output logic              IFIDWrite,
  output logic              Bubble
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [15:0]       StallCount
`endif
);

  // Control packing: {RegWrite, MemRead, MemWrite, MemToReg, ALUSrc, RegDst, ALUOp[3:0]}
  localparam int CTRL_MEMREAD = 8;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_BUBBLE = 1'b1
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [5:0]        id_opcode;
  logic [REG_AW-1:0] id_rs;
  logic [REG_AW-1:0] id_rt;
  logic [REG_AW-1:0] id_rd;
  logic              id_uses_rs;
  logic              id_uses_rt;
  logic              hazard;
  logic              load_bubble;
  logic              capture;
  logic              unused_instr_bits;

  assign id_opcode = IFIDInstr[31:26];
  assign id_rs     = REG_AW'(IFIDInstr[25:21]);
  assign id_rt     = REG_AW'(IFIDInstr[20:16]);
  assign id_rd     = REG_AW'(IFIDInstr[15:11]);

  // Shamt/funct never influence the hazard or the latched fields.
  assign unused_instr_bits = ^IFIDInstr[10:0];

  // Which source registers the decoding instruction actually reads.
  always_comb begin
    id_uses_rs = 1'b1;
    id_uses_rt = 1'b0;
    case (id_opcode)
      OP_RTYPE, OP_SW, OP_BEQ, OP_BNE: id_uses_rt = 1'b1;
      OP_J: id_uses_rs = 1'b0;
      default: ;
    endcase
  end

  // Load-use: the load in EX writes a register the ID instruction reads; r0 never matches.
  always_comb begin
    hazard = 1'b0;
    if (IDEXCtrl[CTRL_MEMREAD] && (IDEXrt != '0)) begin
      if ((id_uses_rs && (IDEXrt == id_rs)) || (id_uses_rt && (IDEXrt == id_rt)))
        hazard = 1'b1;
    end
  end

  // FSM state register.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) state_q <= ST_RUN;
    else      state_q <= state_d;
  end

  // FSM next state: stall holds, flush returns to RUN, load-use in RUN enters BUBBLE.
  always_comb begin
    state_d = state_q;
    if (ExtStall)                         state_d = state_q;
    else if (Flush)                       state_d = ST_RUN;
    else if (hazard && state_q == ST_RUN) state_d = ST_BUBBLE;
    else                                  state_d = ST_RUN;
  end

  // FSM outputs: fetch enables and the register-load selects for this cycle.
  always_comb begin
    PCWrite     = 1'b0;
    IFIDWrite   = 1'b0;
    load_bubble = 1'b0;
    capture     = 1'b0;
    if (!Rst) begin
      PCWrite   = 1'b0;
      IFIDWrite = 1'b0;
    end else if (ExtStall) begin
      PCWrite   = 1'b0;
      IFIDWrite = 1'b0;
    end else if (Flush) begin
      // Fetch handles the redirect and clears IF/ID itself.
      PCWrite     = 1'b1;
      IFIDWrite   = 1'b1;
      load_bubble = 1'b1;
    end else if (hazard && state_q == ST_RUN) begin
      load_bubble = 1'b1;
    end else begin
      PCWrite   = 1'b1;
      IFIDWrite = 1'b1;
      capture   = 1'b1;
    end
  end

  // ID/EX pipeline register: bubble zeroes everything, capture latches decode.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      IDEXOpCode  <= '0;
      IDEXrs      <= '0;
      IDEXrt      <= '0;
      IDEXrd      <= '0;
      IDEXRsData  <= '0;
      IDEXRtData  <= '0;
      IDEXImm     <= '0;
      IDEXPCPlus4 <= '0;
      IDEXCtrl    <= '0;
      Bubble      <= 1'b0;
    end else if (load_bubble) begin
      IDEXOpCode  <= '0;
      IDEXrs      <= '0;
      IDEXrt      <= '0;
      IDEXrd      <= '0;
      IDEXRsData  <= '0;
      IDEXRtData  <= '0;
      IDEXImm     <= '0;
      IDEXPCPlus4 <= '0;
      IDEXCtrl    <= '0;
      Bubble      <= 1'b1;
    end else if (capture) begin
      IDEXOpCode  <= id_opcode;
      IDEXrs      <= id_rs;
      IDEXrt      <= id_rt;
      IDEXrd      <= id_rd;
      IDEXRsData  <= RsData;
      IDEXRtData  <= RtData;
      IDEXImm     <= ImmExt;
      IDEXPCPlus4 <= IFIDPCPlus4;
      IDEXCtrl    <= CtrlIn;
      Bubble      <= 1'b0;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  // Counts bubbles inserted by hazard or flush; saturates rather than wrapping.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst)                                  StallCount <= '0;
    else if (load_bubble && StallCount != '1)  StallCount <= StallCount + 16'd1;
  end
`endif

endmodule
